// File: rtl/bridge_pkg.sv
// Shared definitions for the miniRV MMIO bus bridge.
//   state_e          : bridge FSM states
//   ERR_DATA         : word returned to the CPU for unmapped or timed-out loads
//   *_BASE / *_MASK  : default channel windows (DRAM, digits, LEDs, switches, buttons)
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  localparam logic [31:0] DRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] DRAM_MASK = 32'h0000_0000;
  localparam logic [31:0] DIG_BASE  = 32'hFFFF_F000;
  localparam logic [31:0] DIG_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] LED_BASE  = 32'hFFFF_F060;
  localparam logic [31:0] LED_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] SW_BASE   = 32'hFFFF_F070;
  localparam logic [31:0] SW_MASK   = 32'hFFFF_FFF8;
  localparam logic [31:0] BTN_BASE  = 32'hFFFF_F078;
  localparam logic [31:0] BTN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/addr_decoder.sv
// Combinational address decoder for the MMIO bridge.
//   addr : byte address to decode
//   sel  : one-hot channel select (lowest matching channel index wins)
//   hit  : at least one channel window matched
// A channel matches when (addr & mask) == base.
module addr_decoder #(
  parameter int NUM_DEV = 4,
  parameter int ADDR_W  = 32,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = '0,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = '0
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_DEV-1:0] sel,
  output logic               hit
);

  // Walk from the highest channel down so the lowest-index match is the
  // last one written and therefore takes priority.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU data bus to NUM_DEV slave channel bridge.
// CPU side : req/we/addr/wdata in; rdata (held until next completed load),
//            stall, done (one-cycle pulse), sticky err + err_addr, err_clr.
// Dev side : one-hot dev_req, shared dev_we/dev_addr/dev_wdata from the
//            request latches, flattened dev_rdata and per-channel dev_ack.
// Each access is IDLE (decode) -> ACCESS (wait for ack or timeout) -> RESP
// (done pulse). Unmapped addresses skip ACCESS and report an error.
module mmio_bus_bridge
  import bridge_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = {DIG_BASE, LED_BASE, SW_BASE, DRAM_BASE},
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8, DRAM_MASK}
) (
  input  logic                      clk_from_cpu,
  input  logic                      rst_from_cpu,
  input  logic                      req_from_cpu,
  input  logic                      we_from_cpu,
  input  logic [ADDR_W-1:0]         addr_from_cpu,
  input  logic [DATA_W-1:0]         wdata_from_cpu,
  input  logic                      err_clr,
  output logic [DATA_W-1:0]         rdata_to_cpu,
  output logic                      stall_to_cpu,
  output logic                      done_to_cpu,
  output logic                      err_to_cpu,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [NUM_DEV-1:0]        dev_req,
  output logic                      dev_we,
  output logic [ADDR_W-1:0]         dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]        dev_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_DEV-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

  logic [NUM_DEV-1:0]   dec_sel;
  logic                 dec_hit;
  logic [DATA_W-1:0]    sel_rdata;
  logic                 sel_ack;
  logic                 set_err;
  logic [ADDR_W-1:0]    fault_addr;

  addr_decoder #(
    .NUM_DEV (NUM_DEV),
    .ADDR_W  (ADDR_W),
    .DEV_BASE(DEV_BASE),
    .DEV_MASK(DEV_MASK)
  ) u_dec (
    .addr(addr_from_cpu),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // Only the latched channel's ack and data matter; everything else is ignored.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | dev_rdata[i*DATA_W +: DATA_W];
    end
  end
  assign sel_ack = |(dev_ack & sel_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    set_err      = 1'b0;
    fault_addr   = addr_q;
    stall_to_cpu = 1'b0;
    done_to_cpu  = 1'b0;
    dev_req      = '0;

    case (state_q)
      ST_IDLE: begin
        stall_to_cpu = req_from_cpu;
        if (req_from_cpu) begin
          we_d    = we_from_cpu;
          addr_d  = addr_from_cpu;
          wdata_d = wdata_from_cpu;
          sel_d   = dec_sel;
          if (dec_hit) begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
          end else begin
            state_d    = ST_RESP;
            set_err    = 1'b1;
            fault_addr = addr_from_cpu;
            if (!we_from_cpu) rdata_d = ERR_WORD;
          end
        end
      end

      ST_ACCESS: begin
        stall_to_cpu = 1'b1;
        dev_req      = sel_q;
        cnt_d        = cnt_q + CNT_W'(1);
        // An ack in the last allowed cycle still completes normally.
        if (sel_ack) begin
          if (!we_q) rdata_d = sel_rdata;
          state_d = ST_RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          set_err = 1'b1;
          if (!we_q) rdata_d = ERR_WORD;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        done_to_cpu = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A new error outranks a simultaneous clear.
    if (set_err) begin
      err_d      = 1'b1;
      err_addr_d = fault_addr;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign rdata_to_cpu = rdata_q;
  assign err_to_cpu   = err_q;
  assign err_addr     = err_addr_q;
  assign dev_we       = we_q;
  assign dev_addr     = addr_q;
  assign dev_wdata    = wdata_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Bench for mmio_bus_bridge: channel map ch0 DRAM 0x100-0x1FF, ch1 switches
// 0xFFFF_F070-7, ch2 LEDs 0xFFFF_F060-3, ch3 exactly address 0 (mask all ones).
module tb_mmio_bus_bridge;

  localparam int NUM_DEV = 4;
  localparam int TMO     = 15;
  localparam logic [127:0] BASES = {32'h0000_0000, 32'hFFFF_F060, 32'hFFFF_F070, 32'h0000_0100};
  localparam logic [127:0] MASKS = {32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FF00};

  logic         clk, rst, req, we_i, err_clr;
  logic [31:0]  addr_i, wdata_i;
  logic [31:0]  rdata, err_addr, dev_addr, dev_wdata;
  logic         stall, done, err, dev_we;
  logic [3:0]   dev_req, dev_ack, dev_ack_m, spur_ack;
  logic [127:0] dev_rdata;

  int          wait_cfg[4];
  bit          noack_cfg[4];
  logic [31:0] ch_rdata[4];
  int          reqcnt[4];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_rdata, m_ea;
  bit          m_err;

  mmio_bus_bridge #(
    .NUM_DEV(NUM_DEV), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO),
    .DEV_BASE(BASES), .DEV_MASK(MASKS)
  ) dut (
    .clk_from_cpu(clk), .rst_from_cpu(rst), .req_from_cpu(req),
    .we_from_cpu(we_i), .addr_from_cpu(addr_i), .wdata_from_cpu(wdata_i),
    .err_clr(err_clr), .rdata_to_cpu(rdata), .stall_to_cpu(stall),
    .done_to_cpu(done), .err_to_cpu(err), .err_addr(err_addr),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: count consecutive request cycles, ack once wait_cfg reached.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) reqcnt[i] <= 0;
      else     reqcnt[i] <= dev_req[i] ? reqcnt[i] + 1 : 0;
    end
  end

  always_comb begin
    dev_ack_m = '0;
    dev_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      dev_ack_m[i] = dev_req[i] && !noack_cfg[i] && (reqcnt[i] >= wait_cfg[i]);
      dev_rdata[i*32 +: 32] = ch_rdata[i];
    end
  end
  assign dev_ack = dev_ack_m | spur_ack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_devs(input int w, input bit na, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i]  = w;
      noack_cfg[i] = na;
      ch_rdata[i]  = d;
    end
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_txn(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input bit clr0, input int exp_done, input logic [3:0] exp_sel,
                         input logic [31:0] exp_rd, input bit exp_err, input logic [31:0] exp_ea);
    int got;
    req = 1'b1; we_i = w; addr_i = a; wdata_i = d; err_clr = clr0;
    @(negedge clk);
    chk("stall_cycle0", stall, 1'b1);
    @(posedge clk); #1;
    // Scramble the bus so only the latched request can be seen downstream.
    req = 1'b0; err_clr = 1'b0; we_i = ~w; addr_i = $urandom; wdata_i = $urandom;
    got = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        got = c;
        break;
      end
      chk("stall_access", stall, 1'b1);
      chk("dev_req", dev_req, exp_sel);
      chk("dev_addr", dev_addr, a);
      chk("dev_we", dev_we, w);
      if (w) chk("dev_wdata", dev_wdata, d);
      @(posedge clk); #1;
    end
    chk("done_cycle", got, exp_done);
    chk("stall_resp", stall, 1'b0);
    chk("dev_req_resp", dev_req, 4'b0);
    chk("rdata", rdata, exp_rd);
    chk("err", err, exp_err);
    chk("err_addr", err_addr, exp_ea);
    @(posedge clk); #1;
    chk("done_pulse_end", done, 1'b0);
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & MASKS[i*32 +: 32]) == BASES[i*32 +: 32]) return i;
    return -1;
  endfunction

  // Reference: expected latency/result from the channel map and slave config.
  task automatic model_txn(input logic [31:0] a, input bit w, input logic [31:0] d, input bit clr0);
    int ch, lat;
    bit e;
    logic [3:0] s;
    ch = decode(a);
    s = '0;
    if (ch < 0) begin
      lat = 1; e = 1;
    end else begin
      s[ch] = 1'b1;
      if (noack_cfg[ch] || wait_cfg[ch] > TMO - 1) begin
        lat = TMO + 1; e = 1;
      end else begin
        lat = 2 + wait_cfg[ch]; e = 0;
      end
    end
    if (!w) m_rdata = e ? 32'hDEAD_BEEF : ch_rdata[ch];
    if (e) begin
      m_err = 1; m_ea = a;
    end else if (clr0) begin
      m_err = 0; m_ea = 0;
    end
    run_txn(a, w, d, clr0, lat, s, m_rdata, m_err, m_ea);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          waitc;
    bit          noack;
    logic [31:0] chdata;
    bit          clr0;
    bit          clr_after;
    int          exp_done;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [31:0] exp_ea;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h0000_0100, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 2, 4'b0001, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1] = '{32'hFFFF_F060, 1'b1, 32'hA5, 3, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 5, 4'b0100, 32'h1234_5678, 1'b0, 32'h0};
    tbl[2] = '{32'hFFFF_F070, 1'b0, 32'h0, 0, 1'b1, 32'h7777_7777, 1'b0, 1'b1, 16, 4'b0010, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_F070};
    tbl[3] = '{32'h0000_0004, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 4'b0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0004};
    tbl[4] = '{32'h0000_0000, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 3, 4'b1000, 32'h0BAD_F00D, 1'b1, 32'h0000_0004};
    tbl[5] = '{32'hFFFF_F077, 1'b1, 32'h3C, 14, 1'b0, 32'h0, 1'b0, 1'b0, 16, 4'b0010, 32'h0BAD_F00D, 1'b1, 32'h0000_0004};
    tbl[6] = '{32'hFFFF_F063, 1'b0, 32'h0, 15, 1'b0, 32'h6666_6666, 1'b0, 1'b0, 16, 4'b0100, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_F063};

    rst = 1'b1; req = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    err_clr = 1'b0; spur_ack = '0;
    set_devs(0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_dev_req", dev_req, 4'b0);
    chk("rst_dev_we", dev_we, 1'b0);
    chk("rst_dev_addr", dev_addr, 32'h0);
    chk("rst_dev_wdata", dev_wdata, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      set_devs(tbl[i].waitc, tbl[i].noack, tbl[i].chdata);
      run_txn(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].clr0, tbl[i].exp_done,
              tbl[i].exp_sel, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_ea);
      if (tbl[i].clr_after) begin
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_clr_flag", err, 1'b0);
        chk("err_clr_addr", err_addr, 32'h0);
      end
    end

    // Spurious acks from channel 1 in IDLE and during a channel 0 access.
    set_devs(2, 1'b0, 32'h1111_2222);
    ch_rdata[1] = 32'hBADB_ADBA;
    spur_ack = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spur_idle_done", done, 1'b0);
      chk("spur_idle_stall", stall, 1'b0);
      @(posedge clk); #1;
    end
    run_txn(32'h0000_0180, 1'b0, 32'h0, 1'b0, 4, 4'b0001, 32'h1111_2222, 1'b1, 32'hFFFF_F063);
    spur_ack = '0;

    // Reset in the middle of an access.
    set_devs(10, 1'b0, 32'h4444_4444);
    req = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0100;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_dev_req", dev_req, 4'b0001);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dev_req", dev_req, 4'b0);
    chk("async_rst_stall", stall, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rdata", rdata, 32'h0);
    chk("post_rst_err", err, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 1'b0);
    end
    @(posedge clk); #1;
    m_rdata = 32'h0; m_err = 1'b0; m_ea = 32'h0;
    set_devs(0, 1'b0, 32'h9ABC_DEF0);
    model_txn(32'h0000_0104, 1'b0, 32'h0, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
        wait_cfg[i]  = $urandom_range(0, 16);
        noack_cfg[i] = ($urandom_range(0, 7) == 0);
        ch_rdata[i]  = $urandom;
      end
      case ($urandom_range(0, 5))
        0: a = 32'h0000_0100 | 32'($urandom_range(0, 255));
        1: a = 32'hFFFF_F060 + 32'($urandom_range(0, 3));
        2: a = 32'hFFFF_F070 + 32'($urandom_range(0, 7));
        3: a = 32'h0000_0000;
        4: a = 32'h0000_0004;
        default: a = $urandom;
      endcase
      model_txn(a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
